multicycle_control_unit: RTL

- Multi-cycle control FSM directly upstream of the 16x18-bit register file.
- Accepts one 18-bit instruction at a time over a valid/ready handshake and decodes it.
- Drives the register file's read_register_1, read_register_2, write_register and reg_write, plus ALU and data-memory control, until the instruction retires.

---
 rtl/multicycle_control_unit.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle control FSM sitting in front of the 16x18-bit register file.
// It accepts one 18-bit instruction per valid/ready handshake, decodes it and
// steps it through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK). While
// it does so it drives the register-file addresses and write enable, plus the
// ALU and data-memory controls.
//
// Instruction word: {op[17:14], rd[13:10], rs1[9:6], rs2[5:2] | imm[5:0]}
//   op 0000-0111 R-type ALU   op 1000-1011 I-type ALU   op 1100 LD
//   op 1101 ST                op 1110 BR                op 1111 HALT
//
// All outputs are registered. Each output register is loaded from the value
// that matches the state being entered, so the outputs line up with the
// state register cycle for cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid / instr_ready       instruction handshake (ready only in FETCH)
//   instruction[17:0]               instruction word
//   read_register_1/2[3:0]          register-file read addresses
//   write_register[3:0], reg_write  register-file write address / enable
//   alu_op[3:0], alu_src_imm, imm   ALU controls and immediate field
//   mem_req, mem_we, mem_ready      data-memory handshake
//   halted, fault                   sticky terminal states (left only by reset)
//   retired_count[15:0]             retired instructions (only when the
//                                   RETIRE_COUNT_EN macro is defined)
//
// Optional feature: `define RETIRE_COUNT_EN adds the retired_count output.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int DATA_W      = 18,
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DATA_W-1:0]     instruction,
  output logic [REG_ADDR_W-1:0] read_register_1,
  output logic [REG_ADDR_W-1:0] read_register_2,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic                  reg_write,
  output logic [3:0]            alu_op,
  output logic                  alu_src_imm,
  output logic [5:0]            imm,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  halted,
`ifdef RETIRE_COUNT_EN
  output logic [15:0]           retired_count,
`endif
  output logic                  fault
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT,
    ST_FAULT
  } state_e;

  // ---------------------------------------------------------------------------
  // Opcode class helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_rtype(input logic [3:0] op);
    return op[3] == 1'b0;
  endfunction

  function automatic logic is_itype(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_ld(input logic [3:0] op);
    return op == 4'b1100;
  endfunction

  function automatic logic is_st(input logic [3:0] op);
    return op == 4'b1101;
  endfunction

  function automatic logic is_br(input logic [3:0] op);
    return op == 4'b1110;
  endfunction

  function automatic logic is_halt(input logic [3:0] op);
    return op == 4'b1111;
  endfunction

  // ---------------------------------------------------------------------------
  // State, instruction register and memory-timeout counter
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       ir_q, ir_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;

  // Registered outputs
  logic                    instr_ready_q, instr_ready_d;
  logic [REG_ADDR_W-1:0]   read_register_1_q, read_register_1_d;
  logic [REG_ADDR_W-1:0]   read_register_2_q, read_register_2_d;
  logic [REG_ADDR_W-1:0]   write_register_q, write_register_d;
  logic                    reg_write_q, reg_write_d;
  logic [3:0]              alu_op_q, alu_op_d;
  logic                    alu_src_imm_q, alu_src_imm_d;
  logic [5:0]              imm_q, imm_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic                    halted_q, halted_d;
  logic                    fault_q, fault_d;

  logic [3:0]              op_q;
  logic [3:0]              op_d;
  logic [REG_ADDR_W-1:0]   rd_d, rs1_d, rs2_d;

  assign op_q  = ir_q[17:14];
  assign op_d  = ir_d[17:14];
  assign rd_d  = ir_d[13:10];
  assign rs1_d = ir_d[9:6];
  assign rs2_d = ir_d[5:2];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_cnt_d = tmo_cnt_q;

    unique case (state_q)
      ST_FETCH: begin
        // instr_ready_q is only ever high in FETCH, so this is the handshake.
        if (instr_valid && instr_ready_q) begin
          ir_d    = instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = is_halt(op_q) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_ld(op_q) || is_st(op_q)) begin
          state_d = ST_MEM;
        end else if (is_br(op_q)) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        // A mem_ready on the same edge the timeout would fire takes priority.
        if (mem_ready) begin
          tmo_cnt_d = '0;
          state_d   = is_ld(op_q) ? ST_WRITEBACK : ST_FETCH;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_cnt_d = '0;
          state_d   = ST_FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: computed for the state being entered, from the instruction
  // that will be held in IR, so the registered outputs track the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_ready_d     = 1'b0;
    read_register_1_d = '0;
    read_register_2_d = '0;
    write_register_d  = '0;
    reg_write_d       = 1'b0;
    alu_op_d          = '0;
    alu_src_imm_d     = 1'b0;
    imm_d             = '0;
    mem_req_d         = 1'b0;
    mem_we_d          = 1'b0;
    halted_d          = 1'b0;
    fault_d           = 1'b0;

    unique case (state_d)
      ST_FETCH: begin
        instr_ready_d = 1'b1;
      end
      ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK: begin
        read_register_1_d = rs1_d;
        // Port 2 carries the store data register for ST.
        if (is_rtype(op_d)) begin
          read_register_2_d = rs2_d;
        end else if (is_st(op_d)) begin
          read_register_2_d = rd_d;
        end
        // Memory, branch and halt opcodes all use the ALU as an adder.
        alu_op_d      = (op_d[3:2] != 2'b11) ? op_d : 4'b0000;
        alu_src_imm_d = is_itype(op_d) || is_ld(op_d) || is_st(op_d);
        imm_d         = ir_d[5:0];
        if (state_d == ST_MEM) begin
          mem_req_d = 1'b1;
          mem_we_d  = is_st(op_d);
        end
        if (state_d == ST_WRITEBACK) begin
          write_register_d = rd_d;
          reg_write_d      = 1'b1;
        end
      end
      ST_HALT:  halted_d = 1'b1;
      ST_FAULT: fault_d  = 1'b1;
      default: ;
    endcase
  end

`ifdef RETIRE_COUNT_EN
  // ---------------------------------------------------------------------------
  // Retirement counter: one count per instruction that completes normally.
  // ---------------------------------------------------------------------------
  logic [15:0] retired_count_q, retired_count_d;
  logic        retire;

  always_comb begin
    retire = (state_q == ST_WRITEBACK)
          || (state_q == ST_EXECUTE && is_br(op_q))
          || (state_q == ST_MEM && is_st(op_q) && mem_ready)
          || (state_q == ST_DECODE && is_halt(op_q));
    // Natural 16-bit wrap from 0xFFFF to 0x0000.
    retired_count_d = retired_count_q + {15'b0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count_q <= '0;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;
`endif

  // ---------------------------------------------------------------------------
  // Single register block for state, IR, counter and all outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    if (!rst_n) begin
      // NOTE: the asynchronous reset forces every output low at once, which is
      // what guarantees no partial reg_write once rst_n falls mid-instruction.
      state_q           <= ST_FETCH;
      ir_q              <= '0;
      tmo_cnt_q         <= '0;
      instr_ready_q     <= 1'b0;
      read_register_1_q <= '0;
      read_register_2_q <= '0;
      write_register_q  <= '0;
      reg_write_q       <= 1'b0;
      alu_op_q          <= '0;
      alu_src_imm_q     <= 1'b0;
      imm_q             <= '0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      halted_q          <= 1'b0;
      fault_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      ir_q              <= ir_d;
      tmo_cnt_q         <= tmo_cnt_d;
      instr_ready_q     <= instr_ready_d;
      read_register_1_q <= read_register_1_d;
      read_register_2_q <= read_register_2_d;
      write_register_q  <= write_register_d;
      reg_write_q       <= reg_write_d;
      alu_op_q          <= alu_op_d;
      alu_src_imm_q     <= alu_src_imm_d;
      imm_q             <= imm_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      halted_q          <= halted_d;
      fault_q           <= fault_d;
    end
  end

  assign instr_ready     = instr_ready_q;
  assign read_register_1 = read_register_1_q;
  assign read_register_2 = read_register_2_q;
  assign write_register  = write_register_q;
  assign reg_write       = reg_write_q;
  assign alu_op          = alu_op_q;
  assign alu_src_imm     = alu_src_imm_q;
  assign imm             = imm_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign halted          = halted_q;
  assign fault           = fault_q;

endmodule
